// File: rtl/aes_sbox_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared constants and enums for the time-multiplexed S-box
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;
    localparam int AES_SB_LANES = 4;
    localparam int AES_SB_BEATS = 4;
    localparam int AES_WORD_W   = 32;
    localparam int AES_BEAT_W   = $clog2(AES_SB_BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KX   = 2'd1,
        RD   = 2'd2
    } aes_sb_state_t;

    typedef enum logic {
        GNT_KX = 1'b0,
        GNT_RD = 1'b1
    } aes_sb_grant_t;
endpackage
`default_nettype wire

// File: rtl/aes_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : aes_rr_arb2
// Description : Two-requester round-robin arbiter with registered last-grant
//               flag; grants are only issued while i_en is high.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_rr_arb2
    import aes_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_kx,
    input  logic i_req_rd,
    output logic o_gnt_kx,
    output logic o_gnt_rd
);

    aes_sb_grant_t r_last;

    always_comb begin
        o_gnt_kx = 1'b0;
        o_gnt_rd = 1'b0;
        if (i_en) begin
            if (i_req_kx && i_req_rd) begin
                o_gnt_kx = (r_last == GNT_RD);
                o_gnt_rd = (r_last == GNT_KX);
            end else begin
                o_gnt_kx = i_req_kx;
                o_gnt_rd = i_req_rd;
            end
        end
    end

    // A grant is only given to a valid requester, so every grant is an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= GNT_RD;
        end else if (o_gnt_kx) begin
            r_last <= GNT_KX;
        end else if (o_gnt_rd) begin
            r_last <= GNT_RD;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_sbox_sched.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox_sched
// Description : Shares one external 4-lane S-box between key expansion
//               (one word) and the round datapath (four beats per state).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         kx_req_valid,
    input  logic [31:0]  kx_req_word,
    output logic         kx_req_ready,
    output logic         kx_rsp_valid,
    output logic [31:0]  kx_rsp_word,
    input  logic         rd_req_valid,
    input  logic [127:0] rd_req_block,
    output logic         rd_req_ready,
    output logic         rd_rsp_valid,
    output logic [127:0] rd_rsp_block,
    output logic [31:0]  sb_in,
    input  logic [31:0]  sb_out,
    output logic         busy
);

    localparam int WORD_LG = $clog2(AES_WORD_W);

    aes_sb_state_t                       r_state;
    aes_sb_state_t                       w_state_nxt;
    logic [AES_BEAT_W-1:0]               r_beat;
    logic [AES_WORD_W-1:0]               r_kx_word;
    logic [AES_SB_BEATS*AES_WORD_W-1:0]  r_rd_block;
    logic [AES_WORD_W-1:0]               r_kx_rsp_word;
    logic [AES_SB_BEATS*AES_WORD_W-1:0]  r_rd_rsp_block;
    logic                                r_kx_rsp_valid;
    logic                                r_rd_rsp_valid;
    logic                                w_idle;
    logic                                w_gnt_kx;
    logic                                w_gnt_rd;
    logic                                w_last_beat;
    logic [AES_BEAT_W+WORD_LG-1:0]       w_beat_lsb;

    assign w_idle      = (r_state == IDLE);
    assign w_last_beat = (r_beat == AES_BEAT_W'(AES_SB_BEATS - 1));
    assign w_beat_lsb  = {r_beat, {WORD_LG{1'b0}}};

    aes_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_idle),
        .i_req_kx (kx_req_valid),
        .i_req_rd (rd_req_valid),
        .o_gnt_kx (w_gnt_kx),
        .o_gnt_rd (w_gnt_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        sb_in       = '0;
        case (r_state)
            IDLE: begin
                if (w_gnt_kx) begin
                    w_state_nxt = KX;
                end else if (w_gnt_rd) begin
                    w_state_nxt = RD;
                end
            end
            KX: begin
                sb_in       = r_kx_word;
                w_state_nxt = IDLE;
            end
            RD: begin
                sb_in = r_rd_block[w_beat_lsb +: AES_WORD_W];
                if (w_last_beat) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Response pulses default low each cycle; data registers hold between them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat         <= '0;
            r_kx_word      <= '0;
            r_rd_block     <= '0;
            r_kx_rsp_word  <= '0;
            r_rd_rsp_block <= '0;
            r_kx_rsp_valid <= 1'b0;
            r_rd_rsp_valid <= 1'b0;
        end else begin
            r_kx_rsp_valid <= 1'b0;
            r_rd_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_beat <= '0;
                    if (w_gnt_kx) begin
                        r_kx_word <= kx_req_word;
                    end
                    if (w_gnt_rd) begin
                        r_rd_block <= rd_req_block;
                    end
                end
                KX: begin
                    r_kx_rsp_word  <= sb_out;
                    r_kx_rsp_valid <= 1'b1;
                end
                RD: begin
                    r_rd_rsp_block[w_beat_lsb +: AES_WORD_W] <= sb_out;
                    r_beat <= r_beat + 1'b1;
                    if (w_last_beat) begin
                        r_rd_rsp_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign kx_req_ready = w_gnt_kx;
    assign rd_req_ready = w_gnt_rd;
    assign kx_rsp_valid = r_kx_rsp_valid;
    assign kx_rsp_word  = r_kx_rsp_word;
    assign rd_rsp_valid = r_rd_rsp_valid;
    assign rd_rsp_block = r_rd_rsp_block;
    assign busy         = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_sbox_sched
// Description : Scoreboard bench for aes_sbox_sched with an arithmetic AES
//               S-box model and a cycle-level occupancy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_sbox_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         kx_req_valid = 1'b0;
    logic [31:0]  kx_req_word = '0;
    logic         kx_req_ready;
    logic         kx_rsp_valid;
    logic [31:0]  kx_rsp_word;
    logic         rd_req_valid = 1'b0;
    logic [127:0] rd_req_block = '0;
    logic         rd_req_ready;
    logic         rd_rsp_valid;
    logic [127:0] rd_rsp_block;
    logic [31:0]  sb_in;
    logic [31:0]  sb_out;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // GF(2^8) arithmetic: S(x) = affine(x^254)
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, base, inv;
        int e;
        r = 8'h01; base = x; e = 254;
        while (e > 0) begin
            if (e % 2 == 1) r = gmul(r, base);
            base = gmul(base, base);
            e = e / 2;
        end
        inv = r;
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = sbox(w[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] sub_block(input logic [127:0] b);
        logic [127:0] o;
        for (int i = 0; i < 4; i++) o[32*i +: 32] = sub_word(b[32*i +: 32]);
        return o;
    endfunction

    assign sb_out = sub_word(sb_in);

    aes_sbox_sched dut (
        .clk          (clk),
        .rst          (rst),
        .kx_req_valid (kx_req_valid),
        .kx_req_word  (kx_req_word),
        .kx_req_ready (kx_req_ready),
        .kx_rsp_valid (kx_rsp_valid),
        .kx_rsp_word  (kx_rsp_word),
        .rd_req_valid (rd_req_valid),
        .rd_req_block (rd_req_block),
        .rd_req_ready (rd_req_ready),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_block (rd_rsp_block),
        .sb_in        (sb_in),
        .sb_out       (sb_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t         kx_q[$];
    exp_t         rd_q[$];
    int           m_free   = 0;
    int           m_start  = 0;
    bit           m_job_rd = 1'b0;
    bit           m_last_rd = 1'b1;
    logic [127:0] m_job_data = '0;
    logic [31:0]  kx_hold = '0;
    logic [127:0] rd_hold = '0;

    task automatic check_rsp();
        bit   ek, er;
        exp_t e;
        ek = (kx_q.size() > 0) && (kx_q[0].due == cyc);
        er = (rd_q.size() > 0) && (rd_q[0].due == cyc);
        vectors++;
        if (kx_rsp_valid !== ek || rd_rsp_valid !== er) begin
            miscompares++;
            $display("FAIL rsp_valid cyc=%0d got kx=%b rd=%b exp kx=%b rd=%b",
                     cyc, kx_rsp_valid, rd_rsp_valid, ek, er);
        end
        if (ek) begin
            e = kx_q.pop_front();
            kx_hold = e.data[31:0];
            vectors++;
            if (kx_rsp_word !== kx_hold) begin
                miscompares++;
                $display("FAIL kx_rsp_word cyc=%0d got=%h exp=%h", cyc, kx_rsp_word, kx_hold);
            end
        end
        if (er) begin
            e = rd_q.pop_front();
            rd_hold = e.data;
            vectors++;
            if (rd_rsp_block !== rd_hold) begin
                miscompares++;
                $display("FAIL rd_rsp_block cyc=%0d got=%h exp=%h", cyc, rd_rsp_block, rd_hold);
            end
        end
    endtask

    task automatic check_hold(input bit chk_rd);
        vectors++;
        if (kx_rsp_word !== kx_hold || (chk_rd && rd_rsp_block !== rd_hold)) begin
            miscompares++;
            $display("FAIL rsp_hold cyc=%0d got kx=%h rd=%h exp kx=%h rd=%h",
                     cyc, kx_rsp_word, rd_rsp_block, kx_hold, rd_hold);
        end
    endtask

    task automatic check_cycle();
        int          b;
        logic [31:0] exp_sb;
        bit          ek, er;
        if (cyc < m_free) begin
            b = cyc - m_start - 1;
            exp_sb = m_job_rd ? m_job_data[32*b +: 32] : m_job_data[31:0];
            vectors++;
            if (busy !== 1'b1 || kx_req_ready !== 1'b0 || rd_req_ready !== 1'b0 || sb_in !== exp_sb) begin
                miscompares++;
                $display("FAIL busy_cycle cyc=%0d got busy=%b rk=%b rr=%b sb_in=%h exp busy=1 rk=0 rr=0 sb_in=%h",
                         cyc, busy, kx_req_ready, rd_req_ready, sb_in, exp_sb);
            end
            check_hold(!m_job_rd);
        end else begin
            ek = kx_req_valid && (!rd_req_valid || m_last_rd);
            er = rd_req_valid && (!kx_req_valid || !m_last_rd);
            vectors++;
            if (kx_req_ready !== ek || rd_req_ready !== er || busy !== 1'b0 || sb_in !== 32'h0) begin
                miscompares++;
                $display("FAIL idle_cycle cyc=%0d got rk=%b rr=%b busy=%b sb_in=%h exp rk=%b rr=%b busy=0 sb_in=0",
                         cyc, kx_req_ready, rd_req_ready, busy, sb_in, ek, er);
            end
            check_hold(1'b1);
            if (ek) begin
                kx_q.push_back('{data: {96'h0, sub_word(kx_req_word)}, due: cyc + 2});
                m_free = cyc + 2; m_start = cyc; m_job_rd = 1'b0;
                m_job_data = {96'h0, kx_req_word}; m_last_rd = 1'b0;
            end else if (er) begin
                rd_q.push_back('{data: sub_block(rd_req_block), due: cyc + 5});
                m_free = cyc + 5; m_start = cyc; m_job_rd = 1'b1;
                m_job_data = rd_req_block; m_last_rd = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            check_rsp();
            if (rst) begin
                kx_q.delete();
                rd_q.delete();
                m_free = cyc + 1;
                m_last_rd = 1'b1;
                kx_hold = '0;
                rd_hold = '0;
            end else begin
                check_cycle();
            end
        end
    end

    task automatic kx_send(input logic [31:0] w, input bit keep, output int acc);
        bit got;
        got = 1'b0; acc = -1;
        kx_req_valid = 1'b1; kx_req_word = w;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (kx_req_ready) begin got = 1'b1; acc = cyc; end
        end
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL kx_accept_timeout got=none exp=accept within 100 cycles");
        end
        @(posedge clk); #1;
        if (!keep) kx_req_valid = 1'b0;
        kx_req_word = $urandom;
    endtask

    task automatic rd_send(input logic [127:0] blk, input bit keep, output int acc);
        bit got;
        got = 1'b0; acc = -1;
        rd_req_valid = 1'b1; rd_req_block = blk;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (rd_req_ready) begin got = 1'b1; acc = cyc; end
        end
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL rd_accept_timeout got=none exp=accept within 100 cycles");
        end
        @(posedge clk); #1;
        if (!keep) rd_req_valid = 1'b0;
        rd_req_block = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_rsp(input bit is_rd, output int c);
        bit got;
        got = 1'b0; c = -1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (is_rd ? rd_rsp_valid : kx_rsp_valid) begin got = 1'b1; c = cyc; end
        end
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL rsp_timeout rd=%b got=none exp=pulse within 20 cycles", is_rd);
        end
    endtask

    task automatic expect_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=still running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, tk, tr, prev, rc;
        int kacc[20];
        int racc[20];
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed single requests with hand-derived S-box results
        kx_send(32'hcf4f3c09, 1'b0, t);
        wait_rsp(1'b0, rc);
        expect_eq("kx_latency", 128'(rc), 128'(t + 2));
        expect_eq("kx_word", {96'h0, kx_rsp_word}, {96'h0, 32'h8a84eb01});

        rd_send(128'h0, 1'b0, t);
        wait_rsp(1'b1, rc);
        expect_eq("rd_latency0", 128'(rc), 128'(t + 5));
        expect_eq("rd_block_00", rd_rsp_block, {16{8'h63}});

        rd_send({16{8'h53}}, 1'b0, t);
        wait_rsp(1'b1, rc);
        expect_eq("rd_latency53", 128'(rc), 128'(t + 5));
        expect_eq("rd_block_53", rd_rsp_block, {16{8'hed}});

        // Ties from reset: strict alternation, KX first
        pulse_reset();
        fork
            for (int i = 0; i < 20; i++) kx_send($urandom, i < 19, kacc[i]);
            for (int i = 0; i < 20; i++)
                rd_send({$urandom, $urandom, $urandom, $urandom}, i < 19, racc[i]);
        join
        expect_eq("tie_first_rd_in_kx_rsp_cycle", 128'(racc[0]), 128'(kacc[0] + 2));
        for (int i = 1; i < 20; i++)
            expect_eq("tie_alternation", 128'(kacc[i]), 128'(racc[i-1] + 5));
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back RD throughput
        prev = -1;
        for (int i = 0; i < 10; i++) begin
            rd_send({$urandom, $urandom, $urandom, $urandom}, i < 9, t);
            if (prev >= 0) expect_eq("rd_b2b_spacing", 128'(t - prev), 128'(5));
            prev = t;
        end
        repeat (6) @(posedge clk);
        #1;

        // Reset asserted during beat 2 of an RD transaction
        rd_send({$urandom, $urandom, $urandom, $urandom}, 1'b0, t);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        expect_eq("post_reset_outputs",
                  {rd_rsp_block[95:0], kx_rsp_word},
                  128'h0);
        expect_eq("post_reset_ctrl",
                  {123'h0, kx_req_ready, rd_req_ready, kx_rsp_valid, rd_rsp_valid, busy},
                  128'h0);
        expect_eq("post_reset_sb_in_rdhi", {rd_rsp_block[127:96], sb_in}, 128'h0);
        @(posedge clk); #1;
        fork
            kx_send($urandom, 1'b0, tk);
            rd_send({$urandom, $urandom, $urandom, $urandom}, 1'b0, tr);
        join
        expect_eq("post_reset_tie_kx_first", 128'(tk < tr), 128'(1));
        repeat (6) @(posedge clk);
        #1;

        // Random valids and data
        for (int i = 0; i < 1000; i++) begin
            kx_req_valid = ($urandom_range(0, 2) == 0);
            rd_req_valid = ($urandom_range(0, 2) == 0);
            kx_req_word  = $urandom;
            rd_req_block = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        kx_req_valid = 1'b0;
        rd_req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        expect_eq("outstanding_responses", 128'(kx_q.size() + rd_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
